// File: rtl/occamy_buf_pkg.sv
// -----------------------------------------------------------------------------
// occamy_buf_pkg
// Shared constants and types for the 128b x 2k dual-port packet buffer and
// the engines that access it.
//   AW / DW      : SRAM word-address and data widths
//   SRAM_DEPTH   : number of words in the buffer
//   LW           : burst-length field width; a length of 0 encodes 2**LW words
//   rd_state_e   : read-engine FSM states
//   burst_words  : decodes the burst-length field into a word count
// -----------------------------------------------------------------------------
package occamy_buf_pkg;

  localparam int AW         = 11;
  localparam int DW         = 128;
  localparam int SRAM_DEPTH = 1 << AW;
  localparam int LW         = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_e;

  // Zero in the length field means the maximum burst, 2**LW words.
  function automatic logic [LW:0] burst_words(input logic [LW-1:0] len);
    return (len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, len};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: the head entry is visible on o_dout whenever
// o_empty is low, and i_pop consumes it. Push on full and pop on empty are
// ignored. DEPTH must be a power of two and at least 2.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_push, i_din     : write strobe and data
//   i_pop             : consume the head entry
//   o_dout            : head entry (show-ahead)
//   o_full, o_empty   : occupancy flags
//   o_count           : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: the storage array has no reset; only pointers and count do, so the
  // array maps onto plain registers or RAM without reset fan-out.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/sram_rd_engine.sv
// -----------------------------------------------------------------------------
// sram_rd_engine
// Read-side burst engine for port B of the packet buffer SRAM. A burst request
// (start address, word count) is turned into back-to-back port-B reads; the
// returning words are absorbed in a prefetch FIFO and delivered on a
// valid/ready stream with a last flag. Reads are only issued while
// inflight + fifo_count < FDEPTH, so back-pressure never loses data.
//   i_clk, i_rst                 : clock (also SRAM clkb), async active-high reset
//   i_req_valid/o_req_ready      : burst request handshake (ready = engine idle)
//   i_req_addr, i_req_len        : start word address, length (0 = 64 words)
//   o_sram_enb/web/addrb/dinb    : SRAM port-B controls (read-only use)
//   i_sram_doutb                 : SRAM read data, RD_LAT cycles after issue
//   o_out_valid/i_out_ready      : output word handshake
//   o_out_data, o_out_last       : output word and end-of-burst flag
//   o_busy                       : burst running, reads in flight or FIFO non-empty
// -----------------------------------------------------------------------------
module sram_rd_engine
  import occamy_buf_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FDEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_len,
  output logic          o_sram_enb,
  output logic          o_sram_web,
  output logic [AW-1:0] o_sram_addrb,
  output logic [DW-1:0] o_sram_dinb,
  input  logic [DW-1:0] i_sram_doutb,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_busy
);

  localparam int CW = $clog2(FDEPTH);
  localparam logic [CW+1:0] L_CREDITS = (CW+2)'(FDEPTH);

  rd_state_e     r_state;
  logic          r_alive;
  logic [AW-1:0] r_cur_addr;
  logic [LW:0]   r_remain;
  logic [CW:0]   r_inflight;
  logic [RD_LAT-1:0] r_pipe_v;
  logic [RD_LAT-1:0] r_pipe_last;

  logic          w_credit_ok;
  logic          w_issue;
  logic          w_issue_last;
  logic          w_ret_valid;
  logic          w_ret_last;
  logic          w_pop;
  logic [DW:0]   w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW:0]   w_fifo_count;

  // Credits are computed from registered counts only, so a pop frees a credit
  // from the following cycle on.
  assign w_credit_ok  = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < L_CREDITS;
  assign w_issue      = (r_state == ST_RUN) && w_credit_ok;
  assign w_issue_last = w_issue && (r_remain == (LW+1)'(1));
  assign w_ret_valid  = r_pipe_v[RD_LAT-1];
  assign w_ret_last   = r_pipe_last[RD_LAT-1];
  assign w_pop        = o_out_valid && i_out_ready;

  // Burst FSM and address / remaining-word counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_alive    <= 1'b0;
      r_cur_addr <= '0;
      r_remain   <= '0;
    end else begin
      // Holds req_ready low until the first edge after reset release.
      r_alive <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            r_state    <= ST_RUN;
            r_cur_addr <= i_req_addr;
            r_remain   <= burst_words(i_req_len);
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_cur_addr <= r_cur_addr + 1'b1;  // wraps modulo SRAM_DEPTH
            r_remain   <= r_remain - 1'b1;
            if (w_issue_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Return pipe tracks each read (and its last flag) through the SRAM latency;
  // the in-flight counter mirrors its occupancy for credit accounting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe_v    <= '0;
      r_pipe_last <= '0;
      r_inflight  <= '0;
    end else begin
      r_pipe_v[0]    <= w_issue;
      r_pipe_last[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]    <= r_pipe_v[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      case ({w_issue, w_ret_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  sync_fifo #(
    .W     (DW + 1),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_ret_valid),
    .i_din   ({w_ret_last, i_sram_doutb}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // The credit rule guarantees a returning word always finds a free slot.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
                                  !(w_ret_valid && w_fifo_full));

  assign o_req_ready  = r_alive && (r_state == ST_IDLE);
  assign o_sram_enb   = w_issue;
  assign o_sram_web   = 1'b0;
  assign o_sram_addrb = r_cur_addr;
  assign o_sram_dinb  = '0;
  assign o_out_valid  = !w_fifo_empty;
  assign o_out_data   = w_fifo_dout[DW-1:0];
  // Storage is not reset, so the last flag is qualified with non-empty.
  assign o_out_last   = w_fifo_dout[DW] && !w_fifo_empty;
  assign o_busy       = (r_state == ST_RUN) || (r_inflight != '0) || !w_fifo_empty;

endmodule

// File: tb/tb_sram_rd_engine.sv
module tb_sram_rd_engine;
  import occamy_buf_pkg::*;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_len;
  logic          o_sram_enb;
  logic          o_sram_web;
  logic [AW-1:0] o_sram_addrb;
  logic [DW-1:0] o_sram_dinb;
  logic [DW-1:0] i_sram_doutb;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;
  logic          o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  int n_last   = 0;
  int cycle    = 0;
  int last_issue_cycle = 0;

  logic [AW-1:0] exp_addr_q[$];
  word_t         exp_word_q[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle <= cycle + 1;

  sram_rd_engine #(.RD_LAT(1), .FDEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_len    (i_req_len),
    .o_sram_enb   (o_sram_enb),
    .o_sram_web   (o_sram_web),
    .o_sram_addrb (o_sram_addrb),
    .o_sram_dinb  (o_sram_dinb),
    .i_sram_doutb (i_sram_doutb),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_out_last   (o_out_last),
    .o_busy       (o_busy)
  );

  // Distinct, address-derived contents for every SRAM word.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {21'd0, a};
    return {32'hC0DE_0000 | w, w * 32'd3 + 32'd7, ~w, 32'hA5A5_5A5A ^ w};
  endfunction

  // One-cycle-latency SRAM port B model.
  initial i_sram_doutb = '0;
  always @(posedge i_clk) if (o_sram_enb) i_sram_doutb <= pat(o_sram_addrb);

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s got=event want=none", name);
  endtask

  // Monitor: compares every issued read and every accepted output word
  // against the scoreboard queues.
  initial begin
    word_t w;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_sram_enb) begin
          n_issued++;
          last_issue_cycle = cycle;
          check("sram_web", {128'd0, o_sram_web}, '0);
          check("sram_dinb", {1'b0, o_sram_dinb}, '0);
          if (exp_addr_q.size() == 0) fail_now("unexpected_read");
          else check("sram_addrb", {118'd0, o_sram_addrb}, {118'd0, exp_addr_q.pop_front()});
        end
        if (o_out_valid && i_out_ready) begin
          if (exp_word_q.size() == 0) fail_now("unexpected_word");
          else begin
            w = exp_word_q.pop_front();
            check("out_data", {1'b0, o_out_data}, {1'b0, w.data});
            check("out_last", {128'd0, o_out_last}, {128'd0, w.last});
          end
          if (o_out_last) n_last++;
        end
      end
    end
  end

  task automatic send_req(input logic [AW-1:0] a, input logic [LW-1:0] l, output int acc_cycle);
    int nw;
    logic [AW-1:0] ad;
    acc_cycle = -1;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_len   = l;
    for (int w = 0; w < 500 && !o_req_ready; w++) @(negedge i_clk);
    if (!o_req_ready) begin
      fail_now("req_accept_timeout");
      i_req_valid = 1'b0;
      return;
    end
    acc_cycle = cycle;
    nw = (l == '0) ? 64 : int'(l);
    ad = a;
    for (int i = 0; i < nw; i++) begin
      exp_addr_q.push_back(ad);
      exp_word_q.push_back(word_t'{last: (i == nw - 1), data: pat(ad)});
      ad = ad + 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = 11'h5A5;
    i_req_len   = 6'h2A;
  endtask

  task automatic wait_drain(input string name, output logic busy_before);
    int i;
    i = 0;
    busy_before = o_busy;
    while ((exp_word_q.size() != 0 || exp_addr_q.size() != 0) && i < 3000) begin
      busy_before = o_busy;
      @(posedge i_clk);
      #1;
      i++;
    end
    check_int(name, exp_word_q.size() + exp_addr_q.size(), 0);
  endtask

  initial begin
    int   acc;
    int   base;
    logic bb;
    logic [DW-1:0] hold;

    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_len   = '0;
    i_out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("rst_req_ready", {128'd0, o_req_ready}, '0);
    check("rst_sram_enb",  {128'd0, o_sram_enb},  '0);
    check("rst_sram_addrb", {118'd0, o_sram_addrb}, '0);
    check("rst_out_valid", {128'd0, o_out_valid}, '0);
    check("rst_out_last",  {128'd0, o_out_last},  '0);
    check("rst_busy",      {128'd0, o_busy},      '0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("post_rst_req_ready", {128'd0, o_req_ready}, {128'd0, 1'b1});

    // 1: basic 4-word burst with latency and busy checks.
    send_req(11'h010, 6'd4, acc);
    check("t1_first_enb",  {128'd0, o_sram_enb}, {128'd0, 1'b1});
    check("t1_first_addr", {118'd0, o_sram_addrb}, {118'd0, 11'h010});
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    check("t1_out_valid_latency", {128'd0, o_out_valid}, {128'd0, 1'b1});
    check("t1_first_data", {1'b0, o_out_data}, {1'b0, pat(11'h010)});
    wait_drain("t1_drain", bb);
    check("t1_busy_before_last_pop", {128'd0, bb}, {128'd0, 1'b1});
    check("t1_busy_after_last_pop",  {128'd0, o_busy}, '0);

    // 2: address wrap.
    send_req(11'h7FE, 6'd4, acc);
    wait_drain("t2_drain", bb);

    // 3: len=0 encodes 64 words, one last flag.
    base = n_last;
    send_req(11'h100, 6'd0, acc);
    wait_drain("t3_drain", bb);
    check_int("t3_last_count", n_last - base, 1);

    // 4: back-pressure limits issue to FDEPTH, then one read per pop.
    i_out_ready = 1'b0;
    base = n_issued;
    send_req(11'h200, 6'd16, acc);
    repeat (10) @(posedge i_clk);
    #1;
    check_int("t4_reads_stalled", n_issued - base, 4);
    check("t4_out_valid", {128'd0, o_out_valid}, {128'd0, 1'b1});
    hold = o_out_data;
    @(posedge i_clk);
    #1;
    check("t4_data_stable", {1'b0, o_out_data}, {1'b0, hold});
    check("t4_head_data", {1'b0, o_out_data}, {1'b0, pat(11'h200)});
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_out_ready = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check_int("t4_one_read_per_pop", n_issued - base, 5);
    for (int i = 0; i < 400 && exp_word_q.size() != 0; i++) begin
      @(posedge i_clk);
      #1;
      i_out_ready = (i % 3 != 1);
    end
    i_out_ready = 1'b1;
    wait_drain("t4_drain", bb);
    check_int("t4_total_reads", n_issued - base, 16);

    // 5: back-to-back bursts.
    base = n_last;
    send_req(11'h300, 6'd8, acc);
    send_req(11'h020, 6'd3, acc);
    check_int("t5_accept_after_last_issue", acc, last_issue_cycle + 1);
    wait_drain("t5_drain", bb);
    check_int("t5_last_count", n_last - base, 2);

    // 6: reset in the middle of a burst.
    base = n_issued;
    send_req(11'h400, 6'd8, acc);
    for (int i = 0; i < 50 && (n_issued - base) < 3; i++) begin
      @(posedge i_clk);
      #1;
    end
    check_int("t6_reads_before_rst", n_issued - base, 3);
    i_rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {128'd0, o_out_valid}, '0);
    check("t6_rst_sram_enb",  {128'd0, o_sram_enb},  '0);
    check("t6_rst_busy",      {128'd0, o_busy},      '0);
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("t6_req_ready", {128'd0, o_req_ready}, {128'd0, 1'b1});
    base = n_last;
    send_req(11'h500, 6'd2, acc);
    wait_drain("t6_drain", bb);
    check_int("t6_last_count", n_last - base, 1);

    repeat (3) @(posedge i_clk);
    #1;
    check("end_idle_busy", {128'd0, o_busy}, '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
